// File: rtl/knn_pkg.sv
// Shared FSM state type and distance helper for the k-nearest-neighbour sequencer.
package knn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } knn_state_t;

    // Widest W the distance helper supports; callers zero-extend and truncate.
    localparam int KNN_MAX_W = 64;

    function automatic logic [KNN_MAX_W-1:0] abs_diff(
        input logic [KNN_MAX_W-1:0] a,
        input logic [KNN_MAX_W-1:0] b
    );
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/knn_topk_insert.sv
// Combinational insertion of one (distance, word) pair into an ascending K-slot list.
module knn_topk_insert
    import knn_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 2
) (
    input  logic [K-1:0][W-1:0] dist_in,
    input  logic [K-1:0][W-1:0] word_in,
    input  logic [K-1:0]        valid_in,
    input  logic [W-1:0]        new_dist,
    input  logic [W-1:0]        new_word,
    output logic [K-1:0][W-1:0] dist_out,
    output logic [K-1:0][W-1:0] word_out,
    output logic [K-1:0]        valid_out
);

    logic         placed;
    logic [W-1:0] carry_dist;
    logic [W-1:0] carry_word;
    logic         carry_valid;

    // Strict less-than keeps earlier equal-distance entries below the newcomer;
    // once placed, each following slot takes the displaced entry from the slot below.
    always_comb begin
        dist_out    = dist_in;
        word_out    = word_in;
        valid_out   = valid_in;
        placed      = 1'b0;
        carry_dist  = '0;
        carry_word  = '0;
        carry_valid = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (placed) begin
                dist_out[i]  = carry_dist;
                word_out[i]  = carry_word;
                valid_out[i] = carry_valid;
                carry_dist   = dist_in[i];
                carry_word   = word_in[i];
                carry_valid  = valid_in[i];
            end else if (!valid_in[i] || (new_dist < dist_in[i])) begin
                dist_out[i]  = new_dist;
                word_out[i]  = new_word;
                valid_out[i] = 1'b1;
                carry_dist   = dist_in[i];
                carry_word   = word_in[i];
                carry_valid  = valid_in[i];
                placed       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/knn_seq_ctrl.sv
// Streams N database words per query and reports the K nearest by absolute difference.
// Define KNN_DIST_OUT_EN to add the d_o port carrying the matching distances.
module knn_seq_ctrl
    import knn_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 2,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   query,
    input  logic           db_valid,
    input  logic [W-1:0]   db_data,
    output logic           db_ready,
    output logic           busy,
    output logic           done,
    output logic [W*K-1:0] o
`ifdef KNN_DIST_OUT_EN
    ,
    output logic [W*K-1:0] d_o
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    knn_state_t          state;
    logic [CW-1:0]       cnt;
    logic [W-1:0]        q_reg;
    logic [K-1:0][W-1:0] list_dist;
    logic [K-1:0][W-1:0] list_word;
    logic [K-1:0]        list_valid;

    logic [W-1:0]        beat_dist;
    logic [K-1:0][W-1:0] ins_dist;
    logic [K-1:0][W-1:0] ins_word;
    logic [K-1:0]        ins_valid;

    assign beat_dist = W'(abs_diff(KNN_MAX_W'(db_data), KNN_MAX_W'(q_reg)));

    knn_topk_insert #(
        .W(W),
        .K(K)
    ) u_insert (
        .dist_in  (list_dist),
        .word_in  (list_word),
        .valid_in (list_valid),
        .new_dist (beat_dist),
        .new_word (db_data),
        .dist_out (ins_dist),
        .word_out (ins_word),
        .valid_out(ins_valid)
    );

    // The result registers load from the insertion output on the last beat so the
    // final word is already included when DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            q_reg      <= '0;
            list_dist  <= '1;
            list_word  <= '0;
            list_valid <= '0;
            o          <= '0;
`ifdef KNN_DIST_OUT_EN
            d_o        <= '0;
`endif
            done       <= 1'b0;
            busy       <= 1'b0;
            db_ready   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg      <= query;
                        cnt        <= '0;
                        list_dist  <= '1;
                        list_valid <= '0;
                        state      <= SCAN;
                        busy       <= 1'b1;
                        db_ready   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (db_valid && db_ready) begin
                        list_dist  <= ins_dist;
                        list_word  <= ins_word;
                        list_valid <= ins_valid;
                        if (cnt == CW'(N - 1)) begin
                            state    <= DONE;
                            db_ready <= 1'b0;
                            done     <= 1'b1;
                            o        <= ins_word;
`ifdef KNN_DIST_OUT_EN
                            d_o      <= ins_dist;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    db_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/knn_seq_ctrl.md
KNN_SEQ_CTRL -- requirements
Module: knn_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 32: bit width of the query, database words and distances.
REQ-002 SHALL have parameter K, default 2: number of nearest neighbours returned; 1 <= K <= N.
REQ-003 SHALL have parameter N, default 4: number of database words scanned per query.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request a new query; sampled only in IDLE.
REQ-007 SHALL have port query, input, W: query word, captured on the cycle start is accepted.
REQ-008 SHALL have port db_valid, input, 1: db_data holds a valid database word.
REQ-009 SHALL have port db_data, input, W: database word.
REQ-010 SHALL have port db_ready, output, 1: high only in SCAN.
REQ-011 SHALL have port busy, output, 1: high in SCAN and DONE.
REQ-012 SHALL have port done, output, 1: single-cycle pulse on result completion.
REQ-013 SHALL have port o, output, W*K: K nearest database words; slot 0 (o[W-1:0]) is the nearest.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-015 IDLE SHALL go to SCAN when start=1; in that cycle it captures query, clears the beat counter and sets all K list distances to all-ones with valid=0.
REQ-016 SCAN SHALL accept one beat per cycle when db_valid && db_ready; with db_valid=0 it stalls and keeps all state.
REQ-017 Per beat, distance SHALL be |db_data - query| as unsigned W-bit, with no overflow (larger minus smaller).
REQ-018 Per beat, the word SHALL be inserted into the ascending sorted list only when its distance is strictly less than a valid slot's distance, or when an empty slot exists; lower slots shift up and slot K-1 is dropped.
REQ-019 On equal distance, SHALL keep the earlier-arriving word in the lower slot.
REQ-020 SCAN SHALL go to DONE on the cycle after the N-th accepted beat; the counter counts 0..N-1 without wrap.
REQ-021 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-022 o SHALL update from the sorted list when the FSM enters DONE and SHALL hold until the next DONE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Latency from start to done SHALL be N+1 cycles when db_valid is held high.

Reset
REQ-025 While rst_n=0: state=IDLE, o=0, done=0, busy=0, db_ready=0, counter=0, list distances all-ones, valid bits 0.
REQ-026 Reset asserted during SCAN SHALL abort the query; no done follows reset release.

Configuration
REQ-027 With KNN_DIST_OUT_EN defined, SHALL add output port d_o, W*K wide, holding the distances matching o slot-for-slot, updated and held with o.
REQ-028 Without KNN_DIST_OUT_EN, d_o SHALL be absent and no extra registers for it SHALL be kept.

Structure
REQ-029 Shared package knn_pkg SHALL hold the FSM state enum and the absolute-difference distance function.
REQ-030 Sub-module knn_topk_insert SHALL be combinational sorted-list insertion of one (distance, word) pair into K slots.

Verification (W=8, K=2, N=4)
REQ-031 query=10, db 3,12,20,9 back-to-back -> done at cycle 5 after start, o=16'h0C09.
REQ-032 query=10, db 8,12,11,9 (ties) -> o=16'h090B: 11 before 9, both at d=1.
REQ-033 query=200, db 255,0,199,201 -> distances 55,200,1,1, o=16'hC9C7; with KNN_DIST_OUT_EN, d_o=16'h0101.
REQ-034 Case of REQ-031 with db_valid low for 3 cycles between beats 2 and 3 -> same o; done 3 cycles later.
REQ-035 start pulsed during SCAN -> ignored; result matches the first query only.
REQ-036 rst_n low after beat 2 -> all outputs 0 at once; after release, IDLE with no done pulse.
